// File: rtl/reg_file_sb.sv
// reg_file_sb: register file with two combinational read ports, one write port
// (rising edge) and a per-register busy scoreboard for RAW hazard detection.
//
// Optional feature macro: REG_FILE_BYPASS_EN
//   defined   -> a write in flight is forwarded to a read port addressing the
//                same register in the same cycle
//   undefined -> read ports return stored contents only
//
// Ports:
//   clk_i        clock, rising edge active
//   rst_i        asynchronous reset, active-low
//   RSaddr_i     read port A address       RSdata_o  read port A data
//   RTaddr_i     read port B address       RTdata_o  read port B data
//   RDaddr_i     write address             RDdata_i  write data
//   RegWrite_i   write enable (also clears the busy bit of RDaddr_i)
//   issue_i      mark issue_addr_i busy    issue_addr_i  destination register
//   flush_i      synchronous clear of all busy bits
//   RSbusy_o     busy bit of RSaddr_i      RTbusy_o  busy bit of RTaddr_i
//   busy_cnt_o   number of busy registers (registered)
module reg_file_sb #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5,
  localparam int unsigned CNT_W = ADDR_W + 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [ADDR_W-1:0] RSaddr_i,
  input  logic [ADDR_W-1:0] RTaddr_i,
  output logic [DATA_W-1:0] RSdata_o,
  output logic [DATA_W-1:0] RTdata_o,
  input  logic [ADDR_W-1:0] RDaddr_i,
  input  logic [DATA_W-1:0] RDdata_i,
  input  logic              RegWrite_i,
  input  logic              issue_i,
  input  logic [ADDR_W-1:0] issue_addr_i,
  input  logic              flush_i,
  output logic              RSbusy_o,
  output logic              RTbusy_o,
  output logic [CNT_W-1:0]  busy_cnt_o
);

  localparam int unsigned Depth = 2 ** ADDR_W;

  logic [DATA_W-1:0] regs_q [Depth];
  logic [Depth-1:0]  busy_q, busy_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic wr_en, issue_en;
  logic cnt_inc, cnt_dec;

  // Register 0 is never written nor marked busy.
  assign wr_en    = RegWrite_i && (RDaddr_i != '0);
  assign issue_en = issue_i && (issue_addr_i != '0);

  // Count tracks the popcount incrementally. Set wins over clear on the same
  // address, so a writeback only decrements when it is not being re-issued.
  assign cnt_inc = issue_en && !busy_q[issue_addr_i];
  assign cnt_dec = wr_en && busy_q[RDaddr_i] && !(issue_en && (issue_addr_i == RDaddr_i));

  always_comb begin
    busy_d = busy_q;
    if (wr_en) begin
      busy_d[RDaddr_i] = 1'b0;
    end
    if (issue_en) begin
      busy_d[issue_addr_i] = 1'b1;
    end
    if (flush_i) begin
      busy_d = '0;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (flush_i) begin
      cnt_d = '0;
    end else begin
      unique case ({cnt_inc, cnt_dec})
        2'b10:   cnt_d = cnt_q + CNT_W'(1);
        2'b01:   cnt_d = cnt_q - CNT_W'(1);
        default: cnt_d = cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      for (int i = 0; i < Depth; i++) begin
        regs_q[i] <= '0;
      end
    end else if (wr_en) begin
      regs_q[RDaddr_i] <= RDdata_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      busy_q <= '0;
      cnt_q  <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
    end
  end

  assign busy_cnt_o = cnt_q;

  logic [DATA_W-1:0] rs_stored, rt_stored;
  assign rs_stored = (RSaddr_i == '0) ? '0 : regs_q[RSaddr_i];
  assign rt_stored = (RTaddr_i == '0) ? '0 : regs_q[RTaddr_i];

`ifdef REG_FILE_BYPASS_EN
  logic rs_hit, rt_hit;
  assign rs_hit = wr_en && (RDaddr_i == RSaddr_i);
  assign rt_hit = wr_en && (RDaddr_i == RTaddr_i);

  // A forwarded value is no longer pending unless a new producer issues now.
  always_comb begin
    RSdata_o = rs_stored;
    RTdata_o = rt_stored;
    RSbusy_o = busy_q[RSaddr_i];
    RTbusy_o = busy_q[RTaddr_i];
    if (rs_hit) begin
      RSdata_o = RDdata_i;
      RSbusy_o = issue_en && (issue_addr_i == RSaddr_i);
    end
    if (rt_hit) begin
      RTdata_o = RDdata_i;
      RTbusy_o = issue_en && (issue_addr_i == RTaddr_i);
    end
  end
`else
  always_comb begin
    RSdata_o = rs_stored;
    RTdata_o = rt_stored;
    RSbusy_o = busy_q[RSaddr_i];
    RTbusy_o = busy_q[RTaddr_i];
  end
`endif

endmodule
